// File: rtl/cpu_bus_unit.sv
// Memory-bus sequencer: runs one M-cycle (T1 + strobe T-states, optional wait
// states) per accepted request and returns read data plus the IDU-adjusted address.
module cpu_bus_unit #(
  parameter int unsigned T_PER_M  = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [1:0]  idu_op,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] idu_out,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ready,
  input  logic [7:0]  bus_rdata
);

  typedef enum logic [2:0] {IDLE, T1, STROBE, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  tcnt;
  logic [7:0]  wcnt;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [1:0]  op_q;
  logic        err_q;

  logic        accept, last_t, wait_max, finish_ok, timeout, strobe;
  logic [15:0] idu_val;

  assign accept    = req && (state == IDLE || state == DONE);
  assign last_t    = (state == STROBE) && (tcnt == 4'(T_PER_M - 1));
  assign wait_max  = (state == WAIT) && (wcnt == 8'(MAX_WAIT));
  assign finish_ok = (last_t || state == WAIT) && bus_ready;
  assign timeout   = wait_max && !bus_ready;
  assign strobe    = (state == STROBE) || (state == WAIT);

  always_comb begin
    case (op_q)
      2'd1:    idu_val = bus_addr + 16'd1;
      2'd2:    idu_val = bus_addr - 16'd1;
      default: idu_val = bus_addr;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = T1;
      T1:      state_nx = STROBE;
      STROBE:  if (last_t) state_nx = bus_ready ? DONE : WAIT;
      WAIT:    if (bus_ready || wait_max) state_nx = DONE;
      DONE:    state_nx = req ? T1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and status decode straight from state so async reset drops them at once.
  always_comb begin
    busy      = (state == T1) || strobe;
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    bus_rd    = strobe && !we_q;
    bus_wr    = strobe && we_q;
    bus_wdata = bus_wr ? wdata_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tcnt     <= '0;
      wcnt     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
      rdata    <= '0;
      idu_out  <= '0;
      bus_addr <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bus_addr <= addr;
        we_q     <= we;
        wdata_q  <= wdata;
        op_q     <= idu_op;
      end
      case (state)
        T1:      tcnt <= 4'd1;
        STROBE:  if (!last_t) tcnt <= tcnt + 4'd1;
                 else if (!bus_ready) wcnt <= 8'd1;
        WAIT:    if (!bus_ready && !wait_max) wcnt <= wcnt + 8'd1;
        default: ;
      endcase
      if (finish_ok || timeout) begin
        err_q   <= timeout;
        idu_out <= idu_val;
        if (!we_q) rdata <= timeout ? 8'hFF : bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Self-checking bench for cpu_bus_unit: directed vector table, randomized
// transactions against a transaction-level model, and a mid-transfer reset.
module tb_cpu_bus_unit;
  localparam int unsigned T  = 4;
  localparam int unsigned MW = 8;

  logic        clk = 1'b0;
  logic        rst, req, we, busy, done, err, bus_rd, bus_wr, bus_ready;
  logic [15:0] addr, idu_out, bus_addr;
  logic [7:0]  wdata, rdata, bus_wdata, bus_rdata;
  logic [1:0]  idu_op;

  int unsigned checks = 0, failures = 0;
  logic [7:0]  prev_rdata = '0;
  logic [15:0] prev_idu = '0;

  cpu_bus_unit #(.T_PER_M(T), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .idu_op(idu_op), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .idu_out(idu_out), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [1:0]  op;
    logic [7:0]  brd;
    int unsigned k;
    logic        b2b;
    logic [15:0] e_idu;
    logic [7:0]  e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_idu(input logic [15:0] a, input logic [1:0] op);
    if (op == 2'd1) return a + 16'd1;
    if (op == 2'd2) return a - 16'd1;
    return a;
  endfunction

  task automatic idle_cycle();
    req = 1'b0;
    @(negedge clk);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_strobe", 16'({bus_rd, bus_wr}), 16'd0);
  endtask

  // Called at a negedge; returns at the negedge of the expected done cycle.
  // Cycle c counts clock edges since the accepting edge; ready is low for k
  // cycles starting at the last strobe T-state.
  task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] wd,
                      input logic [1:0] op, input logic [7:0] brd, input int unsigned k,
                      input logic [15:0] e_idu, input logic [7:0] e_rd, input logic e_err,
                      input logic junk);
    int unsigned done_c;
    logic rdy;
    done_c = T + ((k > MW) ? MW : k);
    req = 1'b1; we = w; addr = a; wdata = wd; idu_op = op;
    bus_ready = 1'($urandom); bus_rdata = 8'($urandom);
    @(posedge clk);
    for (int unsigned c = 0; c <= done_c; c++) begin
      @(negedge clk);
      rdy = (c < T - 1) ? 1'($urandom) : (c >= T - 1 + k);
      bus_ready = rdy;
      bus_rdata = (rdy && c >= T - 1) ? brd : 8'($urandom);
      if (junk && c < done_c) begin
        req = 1'($urandom); we = 1'($urandom); addr = 16'($urandom);
        wdata = 8'($urandom); idu_op = 2'($urandom);
      end else begin
        req = 1'b0;
      end
      chk("bus_addr", bus_addr, a);
      if (c < done_c) begin
        chk("busy", 16'(busy), 16'd1);
        chk("done_early", 16'(done), 16'd0);
        chk("err_early", 16'(err), 16'd0);
        chk("bus_rd", 16'(bus_rd), 16'(!w && c >= 1));
        chk("bus_wr", 16'(bus_wr), 16'(w && c >= 1));
        chk("bus_wdata", 16'(bus_wdata), (w && c >= 1) ? 16'(wd) : 16'd0);
        chk("rdata_hold", 16'(rdata), 16'(prev_rdata));
        chk("idu_hold", idu_out, prev_idu);
      end else begin
        chk("done", 16'(done), 16'd1);
        chk("busy_done", 16'(busy), 16'd0);
        chk("err", 16'(err), 16'(e_err));
        chk("strobe_done", 16'({bus_rd, bus_wr}), 16'd0);
        chk("wdata_done", 16'(bus_wdata), 16'd0);
        chk("rdata", 16'(rdata), 16'(e_rd));
        chk("idu_out", idu_out, e_idu);
      end
    end
    prev_rdata = e_rd;
    prev_idu = e_idu;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'hC123, 8'h00, 2'd1, 8'h5A, 0, 1'b0, 16'hC124, 8'h5A, 1'b0};
    vecs[1] = '{1'b1, 16'hFF80, 8'h3C, 2'd2, 8'hEE, 0, 1'b0, 16'hFF7F, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 8'h00, 2'd1, 8'h11, 0, 1'b0, 16'h0000, 8'h11, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 2'd2, 8'h22, 0, 1'b0, 16'hFFFF, 8'h22, 1'b0};
    vecs[4] = '{1'b0, 16'h1234, 8'h00, 2'd0, 8'h99, 2, 1'b0, 16'h1234, 8'h99, 1'b0};
    vecs[5] = '{1'b0, 16'h4000, 8'h00, 2'd3, 8'h77, 9, 1'b0, 16'h4000, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 16'h8000, 8'hA5, 2'd1, 8'h00, 8, 1'b0, 16'h8001, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 16'h0001, 8'h44, 2'd2, 8'h00, 9, 1'b0, 16'h0000, 8'hFF, 1'b1};
    vecs[8] = '{1'b0, 16'h0100, 8'h00, 2'd1, 8'h01, 0, 1'b0, 16'h0101, 8'h01, 1'b0};
    vecs[9] = '{1'b0, 16'h0101, 8'h00, 2'd1, 8'h02, 0, 1'b1, 16'h0102, 8'h02, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; idu_op = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 16'({busy, done, err, bus_rd, bus_wr}), 16'd0);
    chk("rst_data", 16'({rdata, bus_wdata}), 16'd0);
    chk("rst_idu", idu_out, 16'd0);
    chk("rst_addr", bus_addr, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].b2b) idle_cycle();
      xfer(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].op, vecs[i].brd, vecs[i].k,
           vecs[i].e_idu, vecs[i].e_rd, vecs[i].e_err, i >= 8);
    end

    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [15:0] a;
      logic [1:0]  op;
      logic [7:0]  brd;
      int unsigned k;
      w = 1'($urandom); a = 16'($urandom); op = 2'($urandom); brd = 8'($urandom);
      k = $urandom_range(0, 11);
      if ($urandom_range(0, 1) == 0) idle_cycle();
      xfer(w, a, 8'($urandom), op, brd, k, ref_idu(a, op),
           w ? prev_rdata : ((k > MW) ? 8'hFF : brd), k > MW, 1'($urandom));
    end

    idle_cycle();
    req = 1'b1; we = 1'b0; addr = 16'h2222; idu_op = 2'd1; bus_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_rd", 16'(bus_rd), 16'd1);
    rst = 1'b1;
    #1;
    chk("async_rd", 16'(bus_rd), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 16'(done), 16'd0);
    end
    rst = 1'b0;
    prev_rdata = '0;
    prev_idu = '0;
    xfer(1'b0, 16'h3456, 8'h00, 2'd2, 8'hC3, 1, 16'h3455, 8'hC3, 1'b0, 1'b0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_bus_unit.md
Name: cpu_bus_unit

Overview:
- Memory-bus sequencer between the CPU control unit and the external 8-bit data / 16-bit address bus.
- The control unit issues one transfer per request, using the register-file pair output as the address and the 8-bit register output as write data.
- The unit runs one M-cycle of T-states on the bus. It returns read data for the register-file 8-bit write port, plus the IDU-adjusted address (HL+/HL-/SP±/PC+) for the 16-bit write port.

Parameters:
T_PER_M, 4, clock cycles per M-cycle (T1 + strobe T-states); legal range 2..15
MAX_WAIT, 8, max extra stall cycles with bus_ready low before abort; legal range 1..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  start transfer; sampled only in IDLE or DONE
we  input  1  1=write, 0=read; sampled with req
addr  input  16  transfer address (register-file pair read data)
wdata  input  8  write data (register-file 8-bit read data)
idu_op  input  2  0=none, 1=inc, 2=dec, 3=none; sampled with req
busy  output  1  high from acceptance until the cycle before DONE
done  output  1  one-cycle completion pulse
err  output  1  high with done when the transfer aborted on timeout
rdata  output  8  read data; valid while done=1; held until next done
idu_out  output  16  IDU result; valid while done=1; held until next done
bus_addr  output  16  external address
bus_wdata  output  8  external write data
bus_rd  output  1  read strobe
bus_wr  output  1  write strobe
bus_ready  input  1  target ready; sampled on the last strobe T-state and in WAIT
bus_rdata  input  8  external read data

Behaviour:
- Async reset state: IDLE, and all outputs 0: busy, done, err, rdata, idu_out, bus_addr, bus_wdata, bus_rd, bus_wr. Internal counters are 0.
- Reset asserted mid-transfer drops the strobes immediately with no done pulse. The first req after deassertion is accepted normally.
- States: IDLE, T1, STROBE, WAIT, DONE.
- IDLE or DONE with req=1: at the clock edge, latch addr/we/wdata/idu_op, set busy=1, set bus_addr=addr, go to T1. Otherwise DONE returns to IDLE.
- T1 (1 cycle): bus_addr is stable; bus_rd=bus_wr=0; tcnt<=1; go to STROBE.
- STROBE (tcnt = 1..T_PER_M-1):
  - Read: bus_rd=1.
  - Write: bus_wr=1 and bus_wdata=latched wdata. bus_wdata is 0 whenever bus_wr=0.
  - At tcnt=T_PER_M-1: if bus_ready=1, capture bus_rdata for reads and go to DONE. Otherwise go to WAIT with wcnt=1.
- WAIT: strobe stays asserted.
  - bus_ready=1: capture and go to DONE.
  - bus_ready=0 and wcnt=MAX_WAIT: go to DONE with err=1; rdata=8'hFF for reads.
  - Otherwise wcnt increments.
- DONE (1 cycle):
  - done=1, busy=0, strobes=0, bus_addr held.
  - idu_out = latched addr +1 / -1 / +0, modulo 2^16 (FFFF+1=0000, 0000-1=FFFF). The IDU result is produced even on err.
  - For writes, rdata keeps its previous value.
- req while busy=1 is ignored, not queued.
- Latency without stalls: done is high in the cycle T_PER_M clock edges after the accepting edge. Back-to-back throughput is one transfer per T_PER_M+1 cycles (req held through DONE).
- bus_addr changes only at acceptance; it never changes while a strobe is high.
- Read-data capture edge: the edge leaving STROBE/WAIT with ready=1.

Test Plan:
- Read, T_PER_M=4, addr=C123, idu_op=inc, bus_rdata=5A, ready=1 → bus_rd high for 3 cycles after T1; done 4 edges after accept; rdata=5A, idu_out=C124, err=0.
- Write, addr=FF80, wdata=3C, idu_op=dec → bus_wr high 3 cycles with bus_wdata=3C; bus_wdata=00 otherwise; done with idu_out=FF7F; rdata unchanged.
- IDU wrap: addr=FFFF inc → idu_out=0000; addr=0000 dec → idu_out=FFFF.
- Stall: bus_ready low for 2 cycles at the last T-state, bus_rdata=99 → two WAIT cycles, done 6 edges after accept, rdata=99. Stall >MAX_WAIT=8 → done+err, rdata=FF, strobe drops.
- Back-to-back reads to 0100 then 0101 with req held through DONE → second T1 follows DONE directly; req pulses while busy are ignored. Reset asserted mid-STROBE → bus_rd=0 asynchronously, no done; a fresh read after release completes normally.
